// File: rtl/rc4_ctrl.sv
// rc4_ctrl: RC4 sequencer driving an external 256x8 S-box RAM through INIT, KSA and PRGA,
// streaming keystream bytes over valid/ready.
module rc4_ctrl #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   ks_valid,
  output logic [7:0]             ks_data,
  input  logic                   ks_ready,
  output logic                   wen,
  output logic [7:0]             raddr_1,
  output logic [7:0]             waddr_2,
  output logic [7:0]             wdata_2,
  output logic [7:0]             addr_3,
  output logic [7:0]             wdata_3,
  input  logic [7:0]             rdata_1,
  input  logic [7:0]             rdata_3
);
  localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
  typedef enum logic [2:0] {IDLE, INIT, KSA_RD, KSA_SW, PR_RD, PR_SW, PR_OUT, HOLD} state_t;
  state_t state, state_n;
  logic [7:0] i, j, si, sj, i_n, j_n, si_n, sj_n, ks_n, kbyte;
  logic [KW-1:0] kidx, kidx_n;
  assign kbyte = 8'(key >> {kidx, 3'b000});
  assign busy = state != IDLE;
  assign ks_valid = state == HOLD;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      si <= '0;
      sj <= '0;
      kidx <= '0;
      ks_data <= '0;
    end else begin
      state <= state_n;
      i <= i_n;
      j <= j_n;
      si <= si_n;
      sj <= sj_n;
      kidx <= kidx_n;
      ks_data <= ks_n;
    end
  end
  always_comb begin
    state_n = state;
    i_n = i;
    j_n = j;
    si_n = si;
    sj_n = sj;
    kidx_n = kidx;
    ks_n = ks_data;
    wen = 1'b0;
    raddr_1 = '0;
    waddr_2 = '0;
    wdata_2 = '0;
    addr_3 = '0;
    wdata_3 = '0;
    case (state)
      IDLE: begin
        state_n = start ? INIT : IDLE;
        i_n = '0;
      end
      INIT: begin
        wen = 1'b1;
        waddr_2 = i;
        wdata_2 = i;
        addr_3 = i + 8'd1;
        wdata_3 = i + 8'd1;
        i_n = i + 8'd2;
        state_n = i == 8'd254 ? KSA_RD : INIT;
        j_n = '0;
        kidx_n = '0;
      end
      KSA_RD: begin
        raddr_1 = i;
        si_n = rdata_1;
        j_n = j + rdata_1 + kbyte;
        state_n = KSA_SW;
      end
      KSA_SW: begin
        addr_3 = j;
        wen = 1'b1;
        waddr_2 = i;
        wdata_2 = rdata_3;
        wdata_3 = si;
        i_n = i + 8'd1;
        kidx_n = kidx == KW'(KEY_BYTES - 1) ? '0 : kidx + 1'b1;
        state_n = i == 8'hff ? PR_RD : KSA_RD;
        j_n = i == 8'hff ? '0 : j;
      end
      PR_RD: begin
        raddr_1 = i + 8'd1;
        i_n = i + 8'd1;
        si_n = rdata_1;
        j_n = j + rdata_1;
        state_n = PR_SW;
      end
      PR_SW: begin
        addr_3 = j;
        sj_n = rdata_3;
        wen = 1'b1;
        waddr_2 = i;
        wdata_2 = rdata_3;
        wdata_3 = si;
        state_n = PR_OUT;
      end
      PR_OUT: begin
        raddr_1 = si + sj;
        ks_n = rdata_1;
        state_n = HOLD;
      end
      HOLD: state_n = ks_ready ? PR_RD : HOLD;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
endmodule

// File: tb/tb_rc4_ctrl.sv
// tb_rc4_ctrl: random-key RC4 sessions against an array-based RC4 model, with a RAM scoreboard
// and a cycle schedule model for wen/ks_valid.
module tb_rc4_ctrl;
  localparam int KB = 3;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, ks_ready = 0;
  logic [8*KB-1:0] key = '0;
  logic busy, ks_valid, wen;
  logic [7:0] ks_data, raddr_1, waddr_2, wdata_2, addr_3, wdata_3, rdata_1, rdata_3;
  logic [7:0] ram [256];
  logic [7:0] ms [256];
  logic [7:0] cur, b;
  logic [7:0] got [$];
  logic [7:0] v1 [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] v_wiki [6] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
  logic [7:0] v_sec [8] = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
  int n_chk = 0, n_fail = 0, acc = 0, cyc = 0, pstate = -1, mi = 0, mj = 0;
  bit have_cur = 0;

  always #5 clk = ~clk;

  rc4_ctrl #(.KEY_BYTES(KB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key),
    .busy(busy), .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .wen(wen), .raddr_1(raddr_1), .waddr_2(waddr_2), .wdata_2(wdata_2),
    .addr_3(addr_3), .wdata_3(wdata_3), .rdata_1(rdata_1), .rdata_3(rdata_3)
  );

  assign rdata_1 = ram[raddr_1];
  assign rdata_3 = ram[addr_3];
  always @(posedge clk) if (wen) begin
    ram[waddr_2] <= wdata_2;
    ram[addr_3] <= wdata_3;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  task automatic model_ksa(input logic [255:0] k, input int len);
    int jj = 0;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      jj = (jj + ms[x] + k[8*(x%len) +: 8]) % 256;
      t = ms[x]; ms[x] = ms[jj]; ms[jj] = t;
    end
    mi = 0;
    mj = 0;
  endtask

  task automatic model_step(output logic [7:0] o);
    logic [7:0] t;
    mi = (mi + 1) % 256;
    mj = (mj + ms[mi]) % 256;
    t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
    o = ms[(ms[mi] + ms[mj]) % 256];
  endtask

  task automatic ram_cmp(input string nm);
    int bad = -1;
    for (int k = 0; k < 256; k++) if (ram[k] != ms[k] && bad < 0) bad = k;
    chk(nm, bad < 0 ? 0 : int'(ram[bad]), bad < 0 ? 0 : int'(ms[bad]));
  endtask

  // Schedule: cycles 1..128 INIT, 129..640 KSA (RD/SW alternating), then RD, SW, OUT, HOLD loop.
  always @(negedge clk) begin
    if (!busy) begin
      chk("idle_wen", wen, 0);
      chk("idle_valid", ks_valid, 0);
      cyc = 0;
      pstate = -1;
      have_cur = 0;
    end else begin
      cyc++;
      if (cyc == 1) model_ksa(256'(key), KB);
      if (cyc == 641) begin
        pstate = 0;
        ram_cmp("ram_after_ksa");
      end
      if (pstate == 3 && !have_cur) begin
        model_step(cur);
        have_cur = 1;
        ram_cmp("ram_after_swap");
      end
      chk("wen", wen, pstate >= 0 ? int'(pstate == 1) : int'(cyc <= 128 || (cyc - 129) % 2 == 1));
      chk("ks_valid", ks_valid, int'(pstate == 3));
      if (pstate == 3) begin
        chk("ks_data", ks_data, cur);
        if (ks_valid && ks_ready) begin
          acc++;
          got.push_back(ks_data);
          have_cur = 0;
        end
      end
      if (pstate >= 0) pstate = pstate == 3 ? (ks_ready ? 0 : 3) : pstate + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic session(input logic [8*KB-1:0] k);
    key = k;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_bytes(input int n, input bit rnd);
    int tgt = acc + n;
    int bud = 0;
    while (acc < tgt && bud < 700 + 40 * n) begin
      ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      bud++;
    end
    chk("stream_timeout", int'(acc >= tgt), 1);
  endtask

  task automatic stop_session(input string nm);
    abort = 1;
    tick();
    abort = 0;
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_valid"}, ks_valid, 0);
    chk({nm, "_wen"}, wen, 0);
  endtask

  task automatic check_vec1(input string nm);
    for (int k = 0; k < 10; k++) chk(nm, got.size() > k ? int'(got[k]) : -1, v1[k]);
  endtask

  initial begin
    int lat;
    logic [7:0] held;
    model_ksa(256'h79_65_4B, 3);
    for (int k = 0; k < 10; k++) begin model_step(b); chk("pin_key", b, v1[k]); end
    model_ksa(256'h69_6B_69_57, 4);
    for (int k = 0; k < 6; k++) begin model_step(b); chk("pin_wiki", b, v_wiki[k]); end
    model_ksa(256'h74_65_72_63_65_53, 6);
    for (int k = 0; k < 8; k++) begin model_step(b); chk("pin_secret", b, v_sec[k]); end

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", ks_valid, 0);
    chk("rst_wen", wen, 0);
    chk("rst_ks_data", ks_data, 0);
    chk("rst_raddr_1", raddr_1, 0);
    chk("rst_waddr_2", waddr_2, 0);
    chk("rst_wdata_2", wdata_2, 0);
    chk("rst_addr_3", addr_3, 0);
    chk("rst_wdata_3", wdata_3, 0);
    rst_n = 1;
    tick();

    got.delete();
    ks_ready = 1;
    session(24'h79_65_4B);
    lat = 0;
    while (!ks_valid && lat < 1000) begin tick(); lat++; end
    chk("first_valid_cycle", lat, 643);
    wait_bytes(10, 0);
    check_vec1("vec1");
    stop_session("abort_prga");

    got.delete();
    session(24'h79_65_4B);
    repeat (200) tick();
    start = 1;
    tick();
    start = 0;
    wait_bytes(1, 0);
    ks_ready = 0;
    lat = 0;
    while (!ks_valid && lat < 20) begin tick(); lat++; end
    held = ks_data;
    repeat (20) tick();
    chk("bp_valid_held", ks_valid, 1);
    chk("bp_data_stable", ks_data, held);
    wait_bytes(9, 0);
    check_vec1("vec1_backpressure");
    stop_session("abort_bp");

    session(24'h79_65_4B);
    repeat (299) tick();
    stop_session("abort_ksa");
    got.delete();
    session(24'h79_65_4B);
    wait_bytes(10, 0);
    check_vec1("vec1_after_abort");
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", ks_valid, 0);
    chk("midrst_wen", wen, 0);
    chk("midrst_ks_data", ks_data, 0);

    for (int s = 0; s < 4; s++) begin
      session(24'($urandom));
      wait_bytes(30, 1);
      stop_session("abort_rand");
    end
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
